// File: rtl/ssha3_chi_row_if.sv
`default_nettype none
// ============================================================================
// ssha3_chi_row_if : word-addressed memory request/response bus used by the
//                    Keccak-f[800] chi/iota row engine.
// Revision 1.0
// ============================================================================
interface ssha3_chi_row_if #(
   parameter int ADDR_W = 32
) ();
   logic              mem_req;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic [31:0]       mem_rdata;
   logic              mem_rvalid;

   modport master (
      output mem_req, mem_wen, mem_addr, mem_wdata,
      input  mem_gnt, mem_rdata, mem_rvalid
   );

   modport slave (
      input  mem_req, mem_wen, mem_addr, mem_wdata,
      output mem_gnt, mem_rdata, mem_rvalid
   );
endinterface
`default_nettype wire

// File: rtl/ssha3_chi_row.sv
`default_nettype none
// ============================================================================
// ssha3_chi_row : iterative Keccak-f[800] chi/iota engine for one row y.
// Revision 1.0
// ============================================================================
module ssha3_chi_row #(
   parameter int ADDR_W = 32
) (
   input  logic              g_clk,
   input  logic              g_resetn,
   input  logic              start,
   input  logic [2:0]        row_y,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              iota_en,
   input  logic [31:0]       rc,
   output logic              busy,
   output logic              done,
   output logic              err,
   ssha3_chi_row_if.master   mem
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        x_q;
   logic [2:0]        y_q;
   logic [ADDR_W-1:0] base_q;
   logic              iota_q;
   logic [31:0]       rc_q;
   logic [31:0]       lane_buf [5];
   logic [31:0]       chi_raw  [5];
   logic [4:0]        lane_idx;
   logic [ADDR_W-1:0] lane_addr;
   logic [31:0]       lane_out;

   assign lane_idx  = {2'b00, x_q} + 5'({2'b00, y_q} * 5'd5);
   assign lane_addr = base_q + ADDR_W'({lane_idx, 2'b00});

   // Chi reads only the buffered pre-chi lanes, so write order is irrelevant.
   for (genvar gi = 0; gi < 5; gi++) begin : g_chi
      localparam int N1 = (gi + 1) % 5;
      localparam int N2 = (gi + 2) % 5;
      assign chi_raw[gi] = lane_buf[gi] ^ (~lane_buf[N1] & lane_buf[N2]);
   end

   assign lane_out = chi_raw[x_q] ^
                     ((iota_q && y_q == 3'd0 && x_q == 3'd0) ? rc_q : 32'h0);

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      busy          = 1'b0;
      done          = 1'b0;
      mem.mem_req   = 1'b0;
      mem.mem_wen   = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      case (state)
         S_IDLE: begin
            if (start && row_y <= 3'd4) begin
               state_nxt = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            busy         = 1'b1;
            mem.mem_req  = 1'b1;
            mem.mem_addr = lane_addr;
            if (mem.mem_gnt) begin
               state_nxt = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            busy = 1'b1;
            if (mem.mem_rvalid) begin
               state_nxt = (x_q == 3'd4) ? S_WR_REQ : S_RD_REQ;
            end
         end
         S_WR_REQ: begin
            busy          = 1'b1;
            mem.mem_req   = 1'b1;
            mem.mem_wen   = 1'b1;
            mem.mem_addr  = lane_addr;
            mem.mem_wdata = lane_out;
            if (mem.mem_gnt && x_q == 3'd4) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         x_q    <= '0;
         y_q    <= '0;
         base_q <= '0;
         iota_q <= 1'b0;
         rc_q   <= '0;
         err    <= 1'b0;
         for (int i = 0; i < 5; i++) begin
            lane_buf[i] <= '0;
         end
      end else begin
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (row_y <= 3'd4) begin
                     y_q    <= row_y;
                     base_q <= base_addr & ~ADDR_W'(3);
                     iota_q <= iota_en;
                     rc_q   <= rc;
                     x_q    <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_RD_WAIT: begin
               if (mem.mem_rvalid) begin
                  lane_buf[x_q] <= mem.mem_rdata;
                  x_q           <= (x_q == 3'd4) ? 3'd0 : x_q + 3'd1;
               end
            end
            S_WR_REQ: begin
               if (mem.mem_gnt && x_q != 3'd4) begin
                  x_q <= x_q + 3'd1;
               end
            end
            S_DONE: begin
               x_q <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ssha3_chi_row.sv
`default_nettype none
// Bench for ssha3_chi_row: random memory slave with backpressure plus a
// lane-level chi/iota reference model.
module tb_ssha3_chi_row;

   typedef struct {
      bit        wen;
      bit [31:0] addr;
      bit [31:0] data;
   } acc_t;

   logic        g_clk = 1'b0;
   logic        g_resetn = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  row_y = '0;
   logic [31:0] base_addr = '0;
   logic        iota_en = 1'b0;
   logic [31:0] rc = '0;
   logic        busy, done, err;

   ssha3_chi_row_if #(.ADDR_W(32)) mif ();

   ssha3_chi_row #(.ADDR_W(32)) dut (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .start     (start),
      .row_y     (row_y),
      .base_addr (base_addr),
      .iota_en   (iota_en),
      .rc        (rc),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem       (mif.master)
   );

   always #5 g_clk = ~g_clk;

   int total = 0;
   int bad = 0;
   bit [31:0] mem [bit [31:0]];
   acc_t log_q [$];
   bit bp = 0;
   bit spur = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] lane_at(input int y, input bit [31:0] base, input int x);
      return (base & 32'hFFFF_FFFC) + 32'(4 * (x + 5 * y));
   endfunction

   // Memory slave: decides gnt/rvalid at the falling edge for the next rising edge.
   bit        rd_pend = 0;
   int        rd_cnt = 0;
   bit [31:0] rd_addr = 0;
   bit        in_req = 0;
   int        wait_left = 0;
   bit        hold_prev = 0;
   logic [31:0] p_addr, p_wdata;
   logic        p_wen;

   initial begin
      mif.mem_gnt = 1'b0;
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata = '0;
   end

   always @(negedge g_clk) begin
      if (!g_resetn) begin
         rd_pend = 0; in_req = 0; wait_left = 0; hold_prev = 0;
         mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_stable", {mif.mem_req, mif.mem_wen, mif.mem_addr, mif.mem_wen ? mif.mem_wdata[30:0] : 31'h0},
                {1'b1, p_wen, p_addr, p_wen ? p_wdata[30:0] : 31'h0});
         end
         mif.mem_rvalid = 1'b0;
         mif.mem_gnt = 1'b0;
         if (rd_pend) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               mif.mem_rvalid = 1'b1;
               mif.mem_rdata = mem[rd_addr];
               rd_pend = 0;
            end
         end
         if (mif.mem_req) begin
            if (!in_req) begin
               in_req = 1;
               wait_left = bp ? int'($urandom_range(0, 5)) : 0;
            end
            if (wait_left == 0) begin
               mif.mem_gnt = 1'b1;
               in_req = 0;
               log_q.push_back('{mif.mem_wen, mif.mem_addr, mif.mem_wdata});
               if (mif.mem_wen) begin
                  mem[mif.mem_addr] = mif.mem_wdata;
               end else begin
                  rd_pend = 1;
                  rd_cnt = bp ? int'($urandom_range(1, 4)) : 1;
                  rd_addr = mif.mem_addr;
               end
            end else begin
               wait_left--;
            end
            if (spur && !mif.mem_rvalid && $urandom_range(0, 2) == 0) begin
               mif.mem_rvalid = 1'b1;
               mif.mem_rdata = $urandom;
            end
         end
         hold_prev = mif.mem_req && !mif.mem_gnt;
         p_addr = mif.mem_addr; p_wen = mif.mem_wen; p_wdata = mif.mem_wdata;
      end
   end

   task automatic set_lanes(input int y, input bit [31:0] base, input bit [31:0] v [5]);
      for (int x = 0; x < 5; x++) mem[lane_at(y, base, x)] = v[x];
   endtask

   // Called at a falling edge; start is sampled at the next rising edge (cycle 0).
   task automatic run_op(input int y, input bit [31:0] base, input bit io,
                         input bit [31:0] r, input bit chk_lat, input bit intrude);
      bit [31:0] a [5];
      bit [31:0] ex [5];
      bit [31:0] ad [5];
      int cyc;
      for (int x = 0; x < 5; x++) begin
         ad[x] = lane_at(y, base, x);
         a[x] = mem[ad[x]];
      end
      for (int x = 0; x < 5; x++) ex[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
      if (io && y == 0) ex[0] ^= r;
      log_q.delete();
      start = 1'b1; row_y = 3'(y); base_addr = base; iota_en = io; rc = r;
      @(negedge g_clk);
      start = 1'b0; row_y = 3'($urandom); base_addr = $urandom; iota_en = 1'($urandom); rc = $urandom;
      cyc = 1;
      while (!done && cyc < 600) begin
         if (intrude && cyc == 4) begin
            start = 1'b1; row_y = 3'((y + 1) % 5); base_addr = base + 32'h100;
         end else begin
            start = 1'b0;
         end
         @(negedge g_clk);
         cyc++;
      end
      start = 1'b0;
      chk("done_seen", done, 1);
      if (chk_lat) chk("latency", cyc, 16);
      chk("busy_in_done", busy, 1);
      @(negedge g_clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      chk("access_count", log_q.size(), 10);
      for (int i = 0; i < 10 && i < log_q.size(); i++) begin
         chk($sformatf("acc%0d_wen", i), log_q[i].wen, (i >= 5));
         chk($sformatf("acc%0d_addr", i), log_q[i].addr, ad[i % 5]);
         if (i >= 5) chk($sformatf("acc%0d_data", i), log_q[i].data, ex[i - 5]);
      end
   endtask

   initial begin
      bit [31:0] v [5];
      int guard;
      repeat (3) @(negedge g_clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_req", mif.mem_req, 0);
      chk("rst_wen", mif.mem_wen, 0);
      chk("rst_addr", mif.mem_addr, 0);
      chk("rst_wdata", mif.mem_wdata, 0);
      #2 g_resetn = 1'b1;
      @(negedge g_clk);

      // Nominal chi vector
      v = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
      set_lanes(2, 32'h1000, v);
      run_op(2, 32'h1000, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("nom_1028", mem[32'h1028], 32'h0);
      chk("nom_102c", mem[32'h102C], 32'h0);
      chk("nom_1030", mem[32'h1030], 32'hFFFF_FFFF);
      chk("nom_1034", mem[32'h1034], 32'hFFFF_FFFF);
      chk("nom_1038", mem[32'h1038], 32'h0);

      // Iota on row 0, then back-to-back on row 1 where it must not apply
      v = '{0, 0, 0, 0, 0};
      set_lanes(0, 32'h0, v);
      set_lanes(1, 32'h0, v);
      run_op(0, 32'h0, 1'b1, 32'h8000_8009, 1'b1, 1'b0);
      chk("iota_w0", mem[32'h0], 32'h8000_8009);
      chk("iota_w4", mem[32'h10], 32'h0);
      run_op(1, 32'h0, 1'b1, 32'h8000_8009, 1'b1, 1'b0);
      chk("iota_y1_w0", mem[32'h14], 32'h0);

      // Illegal row
      start = 1'b1; row_y = 3'd5; base_addr = 32'h4000;
      @(negedge g_clk);
      start = 1'b0;
      chk("ill_err", err, 1);
      chk("ill_busy", busy, 0);
      chk("ill_req", mif.mem_req, 0);
      @(negedge g_clk);
      chk("ill_err_pulse", err, 0);
      chk("ill_busy2", busy, 0);

      // Backpressure, slow responses and spurious rvalid
      bp = 1; spur = 1;
      v = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
      set_lanes(2, 32'h1000, v);
      run_op(2, 32'h1000, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("bp_1030", mem[32'h1030], 32'hFFFF_FFFF);
      chk("bp_1034", mem[32'h1034], 32'hFFFF_FFFF);
      for (int k = 0; k < 4; k++) begin
         int y;
         bit [31:0] b;
         y = int'($urandom_range(0, 4));
         b = $urandom;
         for (int x = 0; x < 5; x++) v[x] = $urandom;
         set_lanes(y, b, v);
         run_op(y, b, 1'($urandom), $urandom, 1'b0, k[0]);
      end

      // Address wrap
      for (int x = 0; x < 5; x++) v[x] = $urandom;
      set_lanes(1, 32'hFFFF_FFF0, v);
      run_op(1, 32'hFFFF_FFF0, 1'b0, 32'h0, 1'b0, 1'b0);
      if (log_q.size() > 0) chk("wrap_first", log_q[0].addr, 32'h4);
      bp = 0; spur = 0;

      // Asynchronous reset during the third write
      v = '{1, 2, 3, 4, 5};
      set_lanes(3, 32'h2000, v);
      start = 1'b1; row_y = 3'd3; base_addr = 32'h2000;
      @(negedge g_clk);
      start = 1'b0;
      guard = 0;
      while (!(mif.mem_req && mif.mem_wen && mif.mem_addr == lane_at(3, 32'h2000, 2)) && guard < 200) begin
         @(negedge g_clk);
         guard++;
      end
      chk("reach_wr2", guard < 200, 1);
      #2 g_resetn = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_req", mif.mem_req, 0);
      chk("arst_done", done, 0);
      @(negedge g_clk);
      @(negedge g_clk);
      #3 g_resetn = 1'b1;
      @(negedge g_clk);
      for (int x = 0; x < 5; x++) v[x] = $urandom;
      set_lanes(4, 32'h0, v);
      run_op(4, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      if (log_q.size() > 4) begin
         chk("post_rst_rd0", log_q[0].addr, 32'h50);
         chk("post_rst_rd4", log_q[4].addr, 32'h60);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ssha3_chi_row.md
Name: ssha3_chi_row

Overview:
- Iterative Keccak-f[800] chi/iota row engine. Sits directly downstream of the ssha3 lane-index unit and consumes the same lane byte-offset mapping: offset = 4*(x + 5*y), 32-bit lanes.
- For one row y, it reads the five lanes from a word-addressed state memory and computes chi, plus iota on lane (0,0) when enabled.
- Writes the five results back and signals completion.

Parameters:
- ADDR_W, 32, width of the memory byte address bus.

Ports:
- g_clk      in   1   clock; all state updates on the rising edge
- g_resetn   in   1   asynchronous active-low reset
- start      in   1   begin a row operation; sampled only in IDLE
- row_y      in   3   row index y; legal values 0..4
- base_addr  in   ADDR_W  byte address of lane (0,0); bits [1:0] treated as 0
- iota_en    in   1   apply round constant to lane (0,0)
- rc         in   32  round constant; captured with start
- busy       out  1   high in every state except IDLE
- done       out  1   one-cycle pulse on completion
- err        out  1   one-cycle pulse when start is given with row_y > 4
- mem_req    out  1   memory request valid
- mem_wen    out  1   1 = write, 0 = read; valid while mem_req is high
- mem_addr   out  ADDR_W  byte address; valid while mem_req is high
- mem_wdata  out  32  write data; valid while mem_req && mem_wen
- mem_gnt    in   1   request accepted this cycle
- mem_rdata  in   32  read data; valid with mem_rvalid
- mem_rvalid in   1   read response; honoured only in RD_WAIT

Behaviour:
- Reset (asynchronous, active-low): state = IDLE; busy, done, err, mem_req, mem_wen = 0; mem_addr, mem_wdata = 0; lane buffers and x counter cleared.
- Start in IDLE with row_y <= 4:
  - Capture row_y, base_addr (low 2 bits forced to 0), iota_en and rc.
  - Set x = 0 and go to RD_REQ.
- Start in IDLE with row_y >= 5: no state change; err pulses the next cycle.
- Start outside IDLE: ignored. Captured inputs stay stable for the whole operation.
- Lane address for lane x of the captured row: base + 4*(x + 5*y), computed at ADDR_W width, wraps modulo 2^ADDR_W.
- States and transitions:
  - RD_REQ: mem_req = 1, mem_wen = 0, address of lane x. Hold all request signals until mem_gnt. On gnt, go to RD_WAIT.
  - RD_WAIT: mem_req = 0. On mem_rvalid, buf[x] = mem_rdata. Then if x == 4, set x = 0 and go to WR_REQ; otherwise x += 1 and go to RD_REQ.
  - WR_REQ: mem_req = 1, mem_wen = 1, address of lane x, mem_wdata = out[x]. Hold until mem_gnt. On gnt, if x == 4 go to DONE; otherwise x += 1.
  - DONE: done = 1 for exactly one cycle, busy = 1, then go to IDLE.
- At most one read outstanding. mem_rvalid outside RD_WAIT is ignored, including when it coincides with a gnt cycle.
- Chi, with indices mod 5: out[x] = buf[x] ^ (~buf[x+1] & buf[x+2]).
- Iota: if iota_en && y == 0, out[0] ^= rc.
- All writes use the buffered pre-chi values, so write order does not affect results.
- Minimum latency, with gnt in the request cycle and rvalid the following cycle:
  - start sampled at cycle 0; reads occupy cycles 1-10; writes cycles 11-15; done at cycle 16.
- Back-to-back: a start in the cycle after done is accepted.
- Reset mid-operation aborts immediately. No partial-write guarantee; mem_req drops asynchronously.

Test Plan:
- Nominal chi: base = 0x1000, y = 2, lanes 0x1028..0x1038 = {FFFFFFFF, 0, FFFFFFFF, 0, 0}, gnt always 1, rvalid 1 cycle later -> reads at 0x1028, 0x102C, 0x1030, 0x1034, 0x1038, then writes {0, 0, FFFFFFFF, FFFFFFFF, 0} to the same addresses; done exactly 16 cycles after start.
- Iota: y = 0, base = 0, all lanes 0, iota_en = 1, rc = 0x80008009 -> word 0x0 written 0x80008009, other four lanes written 0. Same stimulus with y = 1 (iota_en = 1) -> all five written 0.
- Backpressure: mem_gnt randomly low for 0-5 cycles, rvalid delay 1-4 cycles, plus spurious rvalid pulses in RD_REQ/WR_REQ -> mem_addr/mem_wen/mem_wdata stable while req && !gnt; spurious rvalid ignored; results identical to the nominal case.
- Illegal row: start with row_y = 5 -> err pulses one cycle, busy stays 0, no mem_req. Start while busy -> ignored, and the current operation's addresses are unchanged.
- Async reset: assert g_resetn = 0 during WR_REQ x = 2 -> busy, mem_req, done = 0 immediately. After release, a new start with y = 4, base = 0 reads 0x50..0x60 correctly.
- Address wrap: ADDR_W = 32, base = 0xFFFFFFF0, y = 1 -> lane 5 at 0x00000004, with addresses wrapping modulo 2^32.
